dram_reader: RTL and testbench

DRAM_READER -- requirements
Module: dram_reader

---
 rtl/dram_reader.sv | 134 +++++++++++++
 tb/tb_dram_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_reader.sv
// dram_reader: dumps a block of 16-bit data RAM words as a big-endian byte
// stream over a valid/ready handshake, one synchronous RAM read per word.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle dump request, honoured only when idle
//   base_addr, word_count first word address and word count (0 is legal)
//   busy, done            busy outside IDLE, one-cycle completion pulse
//   ram_addr, ram_rd_en   RAM read port (data returns one cycle later)
//   ram_data              RAM read data
//   byte_out, byte_valid  outgoing byte stream, high byte of each word first
//   byte_ready            sink accepts the current byte
module dram_reader #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND_HI,
        S_SEND_LO,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remain_q;
    logic [DATA_W-1:0] buf_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic              valid_q;
    logic [7:0]        byte_q;

    // All outputs are registered alongside the state, so each one is set
    // on the edge that enters the state in which it must be asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            byte_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= word_count;
                        busy_q   <= 1'b1;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // RAM data is valid during this cycle only.
                    buf_q   <= ram_data;
                    byte_q  <= ram_data[DATA_W-1:DATA_W/2];
                    valid_q <= 1'b1;
                    state_q <= S_SEND_HI;
                end
                S_SEND_HI: begin
                    if (byte_ready) begin
                        byte_q  <= buf_q[DATA_W/2-1:0];
                        state_q <= S_SEND_LO;
                    end
                end
                S_SEND_LO: begin
                    if (byte_ready) begin
                        valid_q  <= 1'b0;
                        byte_q   <= '0;
                        remain_q <= remain_q - ADDR_W'(1);
                        // Address wraps naturally at 2^ADDR_W.
                        addr_q   <= addr_q + ADDR_W'(1);
                        if (remain_q == ADDR_W'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ram_addr   = addr_q;
    assign ram_rd_en  = rd_en_q;
    assign byte_out   = byte_q;
    assign byte_valid = valid_q;

endmodule

// File: tb/tb_dram_reader.sv
// tb_dram_reader: randomized self-checking bench for dram_reader.
// A queue-based reference predicts reads, bytes and timing per dump.
module tb_dram_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [19:0] word_count = '0;
    logic        busy;
    logic        done;
    logic [19:0] ram_addr;
    logic        ram_rd_en;
    logic [15:0] ram_data = '0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    dram_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_rd_en  (ram_rd_en),
        .ram_data   (ram_data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ram_fn(input logic [19:0] a);
        if (a == 20'h00010) return 16'hA1B2;
        if (a == 20'h00011) return 16'hC3D4;
        return a[15:0] ^ {a[3:0], a[19:8]} ^ 16'h5A3C;
    endfunction

    // Synchronous RAM: one-cycle read latency.
    initial forever begin
        @(posedge clk);
        if (ram_rd_en) ram_data <= ram_fn(ram_addr);
    end

    // ready modes: 0 always 1, 1 random, 2 stall 3 cycles on first byte,
    // 3 driven directly by a task.
    int rdy_mode = 0;
    int hold_n = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: byte_ready = 1'b1;
            1: byte_ready = ($urandom_range(0, 9) < 7);
            2: begin
                if (byte_valid && hold_n < 3) begin
                    byte_ready = 1'b0;
                    hold_n++;
                end else begin
                    byte_ready = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Observation at the falling edge.
    logic [19:0] rd_q[$];
    logic [7:0]  by_q[$];
    int cyc = 0;
    int done_n = 0;
    int busy_n = 0;
    int st_cyc = 0;
    int done_cyc = 0;
    int first_v = -1;
    bit stall_p = 1'b0;
    logic [7:0] prev_b = '0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (ram_rd_en) rd_q.push_back(ram_addr);
        if (byte_valid && byte_ready) by_q.push_back(byte_out);
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy) busy_n++;
        if (start && !busy && !rst) st_cyc = cyc;
        if (byte_valid && first_v < 0) first_v = cyc;
        if (stall_p) begin
            chk("hold_valid", {31'd0, byte_valid}, 32'd1);
            chk("hold_data", {24'd0, byte_out}, {24'd0, prev_b});
        end
        stall_p = byte_valid && !byte_ready && !rst;
        prev_b = byte_out;
    end

    task automatic clear_obs();
        rd_q.delete();
        by_q.delete();
        done_n = 0;
        busy_n = 0;
        first_v = -1;
        hold_n = 0;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, ".busy"}, {31'd0, busy}, 32'd0);
        chk({nm, ".done"}, {31'd0, done}, 32'd0);
        chk({nm, ".rd_en"}, {31'd0, ram_rd_en}, 32'd0);
        chk({nm, ".valid"}, {31'd0, byte_valid}, 32'd0);
        chk({nm, ".addr"}, {12'd0, ram_addr}, 32'd0);
        chk({nm, ".byte"}, {24'd0, byte_out}, 32'd0);
    endtask

    task automatic run_dump(input string nm, input logic [19:0] base,
                            input logic [19:0] cnt, input int mode,
                            input bit restart);
        bit seen;
        int n;
        logic [19:0] a;
        logic [15:0] w;
        n = int'(cnt);
        clear_obs();
        rdy_mode = mode;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = $urandom();
        word_count = $urandom_range(1, 7);
        if (restart) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({nm, ".done_seen"}, {31'd0, seen}, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        chk({nm, ".done_cnt"}, done_n, 32'd1);
        chk({nm, ".n_reads"}, rd_q.size(), n);
        chk({nm, ".n_bytes"}, by_q.size(), 2 * n);
        for (int i = 0; i < n; i++) begin
            a = base + 20'(i);
            w = ram_fn(a);
            if (i < rd_q.size())
                chk({nm, ".rd_addr"}, {12'd0, rd_q[i]}, {12'd0, a});
            if (2 * i + 1 < by_q.size()) begin
                chk({nm, ".hi"}, {24'd0, by_q[2*i]}, {24'd0, w[15:8]});
                chk({nm, ".lo"}, {24'd0, by_q[2*i+1]}, {24'd0, w[7:0]});
            end
        end
        if (mode == 0 || mode == 2) begin
            chk({nm, ".cycles"}, done_cyc - st_cyc + 1,
                4 * n + 2 + (mode == 2 && n > 0 ? 3 : 0));
            chk({nm, ".busy_cyc"}, busy_n,
                4 * n + 1 + (mode == 2 && n > 0 ? 3 : 0));
        end
        if (n > 0)
            chk({nm, ".latency"}, first_v - st_cyc, 32'd3);
        else
            chk({nm, ".no_valid"}, first_v, -1);
        chk({nm, ".idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic rst_abort();
        bit seen;
        logic [15:0] w;
        clear_obs();
        rdy_mode = 3;
        byte_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 20'h00200;
        word_count = 20'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (byte_valid) seen = 1'b1;
        end
        chk("abort.valid_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        byte_ready = 1'b1;
        @(posedge clk);
        #1;
        byte_ready = 1'b0;
        w = ram_fn(20'h00200);
        chk("abort.lo_byte", {24'd0, byte_out}, {24'd0, w[7:0]});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("abort");
        repeat (6) @(posedge clk);
        #2;
        chk("abort.reads", rd_q.size(), 32'd1);
        chk("abort.bytes", by_q.size(), 32'd1);
        chk("abort.no_done", done_n, 32'd0);
    endtask

    initial begin
        logic [19:0] b;
        logic [19:0] c;
        int m;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        run_dump("basic", 20'h00010, 20'd2, 0, 1'b0);
        run_dump("stall", 20'h00010, 20'd2, 2, 1'b0);
        run_dump("zero", 20'h00123, 20'd0, 0, 1'b0);
        run_dump("wrap", 20'hFFFFF, 20'd2, 0, 1'b0);
        run_dump("restart", 20'h00400, 20'd3, 0, 1'b1);

        rst_abort();
        run_dump("after_rst", 20'h00010, 20'd2, 0, 1'b0);

        // Reset wins over a simultaneous start.
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        base_addr = 20'h00055;
        word_count = 20'd4;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        check_idle("rst_vs_start");

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) == 0)
                b = 20'hFFFFF - 20'($urandom_range(0, 3));
            else
                b = 20'($urandom());
            c = 20'($urandom_range(0, 5));
            m = $urandom_range(0, 1);
            run_dump("rand", b, c, m, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
